uart_rx_os16: RTL and testbench

UART receive stage feeding the terminal cursor/character-write controller. It recovers 8N1 frames from the asynchronous serial line using 16x oversampling and 3-sample majority voting. Each good byte is delivered as `rx_data` with a one-cycle `rx_flag` pulse, which the controller consumes directly. Frames with a bad stop bit are reported on `frame_err` and are not delivered.

---
 rtl/uart_pkg.sv | 18 +
 rtl/baud_tick_gen.sv | 32 +++
 rtl/uart_rx_os16.sv | 141 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampled UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OS = 16;

    // Rounded clock divider for one oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (os / 2) * baud) / (os * baud);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OS);
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampling with 3-sample majority vote.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_flag,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       busy
);

    logic rx_m;
    logic rx_s;
    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    baud_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .OS    (OS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    rx_state_t  state, state_n;
    logic [3:0] sc, sc_n;
    logic [2:0] bc, bc_n;
    logic [7:0] sh, sh_n;
    logic [2:0] cap, cap_n;
    logic       armed, armed_n;
    logic       flag_n, ferr_n;
    logic [7:0] data_n;
    logic       c9;
    logic       vote;

    // The sc=9 sample is live on the STOP decision tick itself.
    assign c9   = (sc == 4'd9) ? rx_s : cap[2];
    assign vote = (cap[0] & cap[1]) | (cap[0] & c9) | (cap[1] & c9);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sc        <= '0;
            bc        <= '0;
            sh        <= '0;
            cap       <= 3'b111;
            armed     <= 1'b1;
            rx_flag   <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sc        <= sc_n;
            bc        <= bc_n;
            sh        <= sh_n;
            cap       <= cap_n;
            armed     <= armed_n;
            rx_flag   <= flag_n;
            rx_data   <= data_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        sc_n    = sc;
        bc_n    = bc;
        sh_n    = sh;
        cap_n   = cap;
        armed_n = armed;
        flag_n  = 1'b0;
        ferr_n  = 1'b0;
        data_n  = rx_data;
        if (tick) begin
            if (state != IDLE) begin
                sc_n = sc + 4'd1;
                if (sc == 4'd7) cap_n[0] = rx_s;
                if (sc == 4'd8) cap_n[1] = rx_s;
                if (sc == 4'd9) cap_n[2] = rx_s;
            end
            unique case (state)
                IDLE: begin
                    sc_n = '0;
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        sc_n    = 4'd1;
                    end
                end
                START: begin
                    if (sc == 4'd15) begin
                        sc_n = '0;
                        bc_n = '0;
                        state_n = vote ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sc == 4'd15) begin
                        sc_n = '0;
                        sh_n = {vote, sh[7:1]};
                        if (bc == 3'd7) state_n = STOP;
                        else bc_n = bc + 3'd1;
                    end
                end
                STOP: begin
                    // Decide mid-bit so a following start edge is not missed.
                    if (sc == 4'd9) begin
                        state_n = IDLE;
                        sc_n    = '0;
                        if (vote) begin
                            data_n = sh;
                            flag_n = 1'b1;
                        end else begin
                            ferr_n  = 1'b1;
                            armed_n = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized self-checking bench for uart_rx_os16 against a byte-queue model.
module tb_uart_rx_os16;

    localparam int  CLK_HZ = 7_372_800;
    localparam int  BAUD   = 115200;
    localparam real T_BIT  = 640.0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_flag;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    uart_rx_os16 #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_flag  (rx_flag),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         n_err = 0;
    int         n_both = 0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_flag) got.push_back(rx_data);
            if (frame_err) n_err++;
            if (rx_flag && frame_err) n_both++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input realtime bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask

    task automatic clear_mon();
        got.delete();
        exp_q.delete();
        n_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({rx_flag, rx_data, frame_err, busy} !== 11'd0)
            $display("FAIL reset_outputs: got flag=%b data=%h err=%b busy=%b want all 0",
                     rx_flag, rx_data, frame_err, busy);
        else pass_cnt++;
        rst = 1'b0;
        #(2 * T_BIT);
    endtask

    task automatic test_single();
        logic [7:0] g;
        clear_mon();
        exp_q.push_back(8'h41);
        for (int i = 0; i < 2; i++) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) begin
            send_byte(exp_q[i], 1'b1, T_BIT);
            #(2 * T_BIT + $urandom_range(0, 300));
        end
        total_cnt++;
        if (got.size() != exp_q.size())
            $display("FAIL single_count: got %0d want %0d", got.size(), exp_q.size());
        else pass_cnt++;
        foreach (exp_q[i]) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_q[i])
                $display("FAIL single_byte%0d: got %h want %h", i, g, exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (n_err != 0 || busy !== 1'b0)
            $display("FAIL single_idle: got err=%0d busy=%b want 0/0", n_err, busy);
        else pass_cnt++;
        last_good = exp_q[exp_q.size()-1];
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        clear_mon();
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h41);
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1, T_BIT);
        #(2 * T_BIT);
        total_cnt++;
        if (got.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d want %0d", got.size(), exp_q.size());
        else pass_cnt++;
        foreach (exp_q[i]) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_q[i])
                $display("FAIL b2b_byte%0d: got %h want %h", i, g, exp_q[i]);
            else pass_cnt++;
        end
        last_good = 8'h41;
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        #(4 * 4 * 10);
        rx = 1'b1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL glitch_start: got busy=%b want 1", busy);
        else pass_cnt++;
        #(2 * T_BIT);
        total_cnt++;
        if (got.size() != 0 || n_err != 0 || busy !== 1'b0)
            $display("FAIL glitch_reject: got flags=%0d errs=%0d busy=%b want 0/0/0",
                     got.size(), n_err, busy);
        else pass_cnt++;
    endtask

    task automatic test_frame_break();
        clear_mon();
        send_byte(8'h55, 1'b0, T_BIT);
        total_cnt++;
        if (n_err != 1 || got.size() != 0)
            $display("FAIL ferr_pulse: got errs=%0d flags=%0d want 1/0", n_err, got.size());
        else pass_cnt++;
        total_cnt++;
        if (rx_data !== last_good)
            $display("FAIL ferr_hold: got %h want %h", rx_data, last_good);
        else pass_cnt++;
        #(30 * T_BIT);
        total_cnt++;
        if (n_err != 1 || got.size() != 0)
            $display("FAIL break_quiet: got errs=%0d flags=%0d want 1/0", n_err, got.size());
        else pass_cnt++;
        rx = 1'b1;
        #(2 * T_BIT);
        send_byte(8'h7E, 1'b1, T_BIT);
        #(2 * T_BIT);
        total_cnt++;
        if (got.size() != 1 || rx_data !== 8'h7E)
            $display("FAIL break_recover: got n=%0d data=%h want 1/7e", got.size(), rx_data);
        else pass_cnt++;
        last_good = 8'h7E;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hA5;
        clear_mon();
        rx = 1'b0;
        #(T_BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(T_BIT);
        end
        rx = b[4];
        #(T_BIT / 2);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        #(12 * T_BIT);
        total_cnt++;
        if (got.size() != 0 || n_err != 0 || rx_data !== 8'h00 || busy !== 1'b0)
            $display("FAIL mid_abort: got flags=%0d errs=%0d data=%h busy=%b want 0/0/00/0",
                     got.size(), n_err, rx_data, busy);
        else pass_cnt++;
        send_byte(8'h3C, 1'b1, T_BIT);
        #(2 * T_BIT);
        total_cnt++;
        if (got.size() != 1 || rx_data !== 8'h3C)
            $display("FAIL mid_next: got n=%0d data=%h want 1/3c", got.size(), rx_data);
        else pass_cnt++;
    endtask

    task automatic test_skew();
        realtime    bt;
        real        f[2];
        logic [7:0] g;
        f[0] = 1.03;
        f[1] = 0.97;
        for (int k = 0; k < 2; k++) begin
            bt = T_BIT / f[k];
            clear_mon();
            exp_q.push_back(8'h55);
            exp_q.push_back(8'hAA);
            exp_q.push_back(8'($urandom));
            foreach (exp_q[i]) send_byte(exp_q[i], 1'b1, bt);
            #(2 * T_BIT);
            total_cnt++;
            if (got.size() != exp_q.size() || n_err != 0)
                $display("FAIL skew%0d_count: got %0d errs=%0d want %0d/0",
                         k, got.size(), n_err, exp_q.size());
            else pass_cnt++;
            foreach (exp_q[i]) begin
                g = (i < got.size()) ? got[i] : 8'hxx;
                total_cnt++;
                if (g !== exp_q[i])
                    $display("FAIL skew%0d_byte%0d: got %h want %h", k, i, g, exp_q[i]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_break();
        test_reset_mid();
        test_skew();
        total_cnt++;
        if (n_both != 0) $display("FAIL flag_err_overlap: got %0d want 0", n_both);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
